// File: rtl/miner_led_pkg.sv
// Shared definitions for the miner LED scheduler: display states, LED patterns
// and the fixed-priority pick between requesting event classes.
package miner_led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RES  = 2'd1,
    ST_ERR  = 2'd2,
    ST_WORK = 2'd3
  } state_e;

  localparam logic [7:0] PAT_WORK   = 8'hAA;
  localparam logic [7:0] PAT_ERR_ON = 8'hFF;
  localparam logic [7:0] PAT_OFF    = 8'h00;

  // Result beats error beats work; no request at all means idle.
  function automatic state_e highest_req(input logic req_res, input logic req_err,
                                         input logic req_work);
    if (req_res)       return ST_RES;
    else if (req_err)  return ST_ERR;
    else if (req_work) return ST_WORK;
    else               return ST_IDLE;
  endfunction

endpackage

// File: rtl/led_hold_timer.sv
// Free-running window counter: counts while enabled, wraps after LIMIT counts,
// and flags the last count of each window on expire.
module led_hold_timer #(
  parameter int LIMIT = 8,
  parameter int CNT_W = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expire = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = expire ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_event_scheduler.sv
// Arbitrates miner status events onto the 8-LED bank: pending-flag latching,
// fixed-priority grant with preemption, timed hold window and error blink.
module led_event_scheduler
  import miner_led_pkg::*;
#(
  parameter int HOLD_CYCLES = 100000000,
  parameter int BLINK_DIV   = 12500000,
  parameter int CNT_W       = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_work,
  input  logic       new_work_88,
  input  logic       new_result,
  input  logic       nonce_err,
  input  logic       hashing,
  output logic [7:0] led,
  output logic       busy,
  output logic [7:0] result_count
);

  state_e     state_q, state_d;
  logic       p_res_q, p_res_d;
  logic       p_err_q, p_err_d;
  logic       p_work_q, p_work_d;
  logic       blink_q, blink_d;
  logic [7:0] led_q, led_d;
  logic       busy_q, busy_d;
  logic [7:0] result_count_q, result_count_d;

  logic   ev_work;
  logic   req_res, req_err, req_work;
  state_e best;
  logic   grant, retrig, enter_err;
  logic   hold_clear, hold_en, hold_expire;
  logic   blink_clear, blink_en, blink_expire;

  led_hold_timer #(
    .LIMIT (HOLD_CYCLES),
    .CNT_W (CNT_W)
  ) u_hold_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (hold_clear),
    .en     (hold_en),
    .expire (hold_expire)
  );

  led_hold_timer #(
    .LIMIT (BLINK_DIV),
    .CNT_W (CNT_W)
  ) u_blink_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (blink_clear),
    .en     (blink_en),
    .expire (blink_expire)
  );

  // Own-class events while showing retrigger the window; a strictly higher
  // request preempts and the preempted class is simply forgotten.
  always_comb begin
    ev_work  = new_work | new_work_88;
    req_res  = p_res_q | new_result;
    req_err  = p_err_q | nonce_err;
    req_work = p_work_q | ev_work;
    best     = highest_req(req_res, req_err, req_work);
    state_d  = state_q;
    retrig   = 1'b0;
    case (state_q)
      ST_IDLE: state_d = best;
      ST_RES: begin
        if (new_result)       retrig  = 1'b1;
        else if (hold_expire) state_d = best;
      end
      ST_ERR: begin
        if (req_res)          state_d = ST_RES;
        else if (nonce_err)   retrig  = 1'b1;
        else if (hold_expire) state_d = best;
      end
      ST_WORK: begin
        if (req_res || req_err) state_d = best;
        else if (ev_work)       retrig  = 1'b1;
        else if (hold_expire)   state_d = best;
      end
      default: state_d = ST_IDLE;
    endcase

    grant     = (state_d != state_q) && (state_d != ST_IDLE);
    enter_err = grant && (state_d == ST_ERR);

    p_res_d  = (p_res_q  | (new_result && state_q != ST_RES))
               & ~(grant && state_d == ST_RES);
    p_err_d  = (p_err_q  | (nonce_err  && state_q != ST_ERR))
               & ~(grant && state_d == ST_ERR);
    p_work_d = (p_work_q | (ev_work    && state_q != ST_WORK))
               & ~(grant && state_d == ST_WORK);

    hold_clear  = grant | retrig;
    hold_en     = (state_q != ST_IDLE);
    blink_clear = enter_err;
    blink_en    = (state_q == ST_ERR);

    blink_d = blink_q;
    if (enter_err) begin
      blink_d = 1'b1;
    end else if (blink_en && blink_expire) begin
      blink_d = ~blink_q;
    end

    result_count_d = result_count_q;
    if (new_result && result_count_q != 8'hFF) begin
      result_count_d = result_count_q + 8'd1;
    end

    // The pattern follows the state being entered, so it lands with it.
    led_d = PAT_OFF;
    case (state_d)
      ST_IDLE: led_d = {4'b0000, {4{hashing}}};
      ST_RES:  led_d = result_count_d;
      ST_ERR:  led_d = blink_d ? PAT_ERR_ON : PAT_OFF;
      ST_WORK: led_d = PAT_WORK;
      default: led_d = PAT_OFF;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      p_res_q        <= 1'b0;
      p_err_q        <= 1'b0;
      p_work_q       <= 1'b0;
      blink_q        <= 1'b0;
      led_q          <= PAT_OFF;
      busy_q         <= 1'b0;
      result_count_q <= 8'h00;
    end else begin
      state_q        <= state_d;
      p_res_q        <= p_res_d;
      p_err_q        <= p_err_d;
      p_work_q       <= p_work_d;
      blink_q        <= blink_d;
      led_q          <= led_d;
      busy_q         <= busy_d;
      result_count_q <= result_count_d;
    end
  end

  assign led          = led_q;
  assign busy         = busy_q;
  assign result_count = result_count_q;

endmodule
